// File: rtl/cpu_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_isa_pkg
// Purpose  : Shared ISA definitions for the fetch/decode pair: opcode
//            encodings, the HALT instruction word, the fetch buffer entry
//            type and the fetch unit state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_isa_pkg;

   localparam int OPCODE_W = 4;

   localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_AND  = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_OR   = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_XOR  = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_SHL  = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_SHR  = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_LDI  = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_LD   = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_ST   = 4'h9;
   localparam logic [OPCODE_W-1:0] OP_BR   = 4'hA;
   localparam logic [OPCODE_W-1:0] OP_CALL = 4'hB;
   localparam logic [OPCODE_W-1:0] OP_RET  = 4'hC;
   localparam logic [OPCODE_W-1:0] OP_NOP  = 4'hD;
   localparam logic [OPCODE_W-1:0] OP_ERR  = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

   localparam int INSTR_W = 16;
   localparam int PC_W    = 16;

   localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      IFU_RUN    = 1'b0,
      IFU_HALTED = 1'b1
   } ifu_state_t;

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fifo
// Purpose  : Synchronous instruction buffer of fetch_entry_t. The head entry
//            is read straight from the storage registers, so a word pushed in
//            one cycle is visible at the head in the next.
// Ports    : clk, rst_n        clock / async active-low reset
//            flush             empty the buffer (wins over push/pop)
//            push, push_data   write one entry
//            pop               retire the head entry (only when valid)
//            head, valid       current head entry and its valid flag
//            count             number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fifo
   import cpu_isa_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign valid = (count != '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch front end. Generates the PC, issues one
//            outstanding imem read at a time, buffers returned words in
//            ifu_fifo and presents {instr, instr_pc} to decode. Handles PC
//            redirects and the decoder's HALT (sticky until reset).
// Config   : IFU_LOCAL_HALT_EN - when defined, fetching stops after a
//            HALT_WORD response is buffered, until the next redirect.
// Ports    : clk, rst_n                      clock / async active-low reset
//            imem_req, imem_addr             registered read request
//            imem_rvalid, imem_rdata         read response
//            instr_valid, instr, instr_pc    buffer head to decode
//            instr_ready                     decode accepts head
//            redirect, redirect_pc           flush and refetch
//            halt_in                         decoder HALT for the head
//            halted                          sticky halt status
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
   import cpu_isa_pkg::*;
#(
   parameter int                ADDR_W     = 16,
   parameter int                DATA_W     = 16,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt_in,
   output logic              halted
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   ifu_state_t        state;
   logic [ADDR_W-1:0] fetch_pc;
   logic              outstanding;
   logic              discard;
   logic              prehalt;
   logic [CNT_W-1:0]  count;

   logic              fire;
   logic              halt_fire;
   logic              redir_act;
   logic              room;
   logic              issue;
   logic              rsp_drop;
   logic              push;
   logic              flush;
   fetch_entry_t      push_data;
   fetch_entry_t      head;

   assign fire      = instr_valid & instr_ready;
   assign halt_fire = (state == IFU_RUN) & halt_in & fire;
   // Halt takes priority over a simultaneous redirect.
   assign redir_act = (state == IFU_RUN) & redirect & ~halt_fire;

   // Buffered words plus the in-flight one must leave a free slot.
   assign room  = ({1'b0, count} + (CNT_W+1)'(outstanding)) < (CNT_W+1)'(FIFO_DEPTH);
   assign issue = (state == IFU_RUN) & ~outstanding & ~redirect & ~halt_fire & ~prehalt & room;

   // Responses to stale requests (pre-redirect or post-halt) never reach decode.
   assign rsp_drop  = discard | redirect | halt_fire | (state == IFU_HALTED);
   assign push      = imem_rvalid & ~rsp_drop;
   assign flush     = redir_act | halt_fire;
   // imem_addr still holds the address of the single outstanding read.
   assign push_data = '{instr: imem_rdata, pc: imem_addr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IFU_RUN;
         halted      <= 1'b0;
         fetch_pc    <= RESET_PC;
         outstanding <= 1'b0;
         discard     <= 1'b0;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
      end else begin
         imem_req <= issue;
         if (issue) begin
            imem_addr   <= fetch_pc;
            fetch_pc    <= fetch_pc + ADDR_W'(1);
            outstanding <= 1'b1;
         end else if (imem_rvalid) begin
            outstanding <= 1'b0;
         end

         if (redir_act) fetch_pc <= redirect_pc;

         if (imem_rvalid)
            discard <= 1'b0;
         else if (redir_act && outstanding)
            discard <= 1'b1;

         if (halt_fire) begin
            state  <= IFU_HALTED;
            halted <= 1'b1;
         end
      end
   end

`ifdef IFU_LOCAL_HALT_EN
   // Stop fetching once a HALT word is buffered; a redirect resumes fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prehalt <= 1'b0;
      else if (redir_act)
         prehalt <= 1'b0;
      else if (push && (imem_rdata == HALT_WORD))
         prehalt <= 1'b1;
   end
`else
   assign prehalt = 1'b0;
`endif

   ifu_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_data (push_data),
      .pop       (fire),
      .head      (head),
      .valid     (instr_valid),
      .count     (count)
   );

   assign instr    = head.instr;
   assign instr_pc = head.pc;

endmodule
`default_nettype wire
